rv_multicycle_ctrl: RTL and testbench

Multi-cycle RV32I control unit that drives the ALU's 4-bit `alu_operation` code and consumes its 32-bit result. It is the ALU's issuing end. It sequences fetch, decode, execute, memory and writeback, and produces every datapath select and write-enable in the MP4 core. The ALU, register file, PC/IR/old-PC/alu_out registers and memory port live in the datapath; this block holds only the FSM and decode logic.

---
 rtl/rv_multicycle_ctrl.sv | 394 +++++++++++++++++++++++++++++++++++++++
 tb/tb_rv_multicycle_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// rv_multicycle_ctrl
//
// Multi-cycle RV32I control unit for the MP4 core. It sequences fetch, decode,
// execute, memory and writeback, issues the ALU operation code, and produces
// every datapath select and write strobe. The datapath (ALU, register file,
// PC/IR/OLD_PC/alu_out registers, memory port) is outside this block.
//
// Parameters:
//   RESET_WAIT     number of S_IDLE cycles after reset release before the
//                  first fetch (1..15)
//
// Configuration macro:
//   CTRL_ILLEGAL_TRAP_EN  defined   : an illegal instruction enters S_TRAP and
//                                     sets the sticky illegal_instr flag
//                         undefined : an illegal instruction is a NOP and
//                                     illegal_instr is tied low
//
// Ports:
//   clk            in   1   rising-edge clock
//   rst_n          in   1   asynchronous active-low reset
//   instr          in  32   IR contents, valid from S_DECODE onward
//   alu_result     in  32   combinational ALU output of the current cycle
//   mem_ready      in   1   memory completes the current request this cycle
//   alu_operation  out  4   ALU operation code
//   alu_src_a      out  2   00 PC, 01 OLD_PC, 10 RS1, 11 ZERO
//   alu_src_b      out  2   00 RS2, 01 IMM, 10 FOUR
//   result_src     out  2   00 ALU_OUT, 01 MEM_DATA, 10 ALU_RESULT, 11 PC
//   pc_src         out  1   0 alu_result, 1 alu_out register
//   pc_lsb_clr     out  1   clear PC bit 0 on this PC write (JALR)
//   addr_src       out  1   memory address: 0 PC, 1 alu_out register
//   pc_write       out  1   PC write strobe
//   ir_write       out  1   IR (and OLD_PC) write strobe
//   reg_write      out  1   register file write strobe
//   mem_req        out  1   memory request
//   mem_we         out  1   memory write enable
//   illegal_instr  out  1   sticky illegal-opcode flag (registered)
//
// Outputs are decoded from the current state and instr (plus mem_ready in
// S_FETCH and alu_result for the branch decision), so an asynchronous reset
// forces every output to 0 as soon as the state register clears.
// ---------------------------------------------------------------------------
module rv_multicycle_ctrl #(
    parameter int unsigned RESET_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic [31:0] alu_result,
    input  logic        mem_ready,
    output logic [3:0]  alu_operation,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  result_src,
    output logic        pc_src,
    output logic        pc_lsb_clr,
    output logic        addr_src,
    output logic        pc_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic        mem_req,
    output logic        mem_we,
    output logic        illegal_instr
);

    // ALU operation codes
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    // Operand selects
    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
    localparam logic [1:0] SRC_A_RS1    = 2'b10;
    localparam logic [1:0] SRC_A_ZERO   = 2'b11;
    localparam logic [1:0] SRC_B_RS2    = 2'b00;
    localparam logic [1:0] SRC_B_IMM    = 2'b01;
    localparam logic [1:0] SRC_B_FOUR   = 2'b10;

    // Writeback result selects
    localparam logic [1:0] RES_ALU_OUT  = 2'b00;
    localparam logic [1:0] RES_MEM_DATA = 2'b01;
    localparam logic [1:0] RES_PC       = 2'b11;

    // RV32I major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [3:0] WAIT_LAST = 4'(RESET_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
`ifdef CTRL_ILLEGAL_TRAP_EN
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
`else
        S_WB     = 3'd5
`endif
    } state_t;

`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam state_t ILLEGAL_NEXT = S_TRAP;
`else
    localparam state_t ILLEGAL_NEXT = S_FETCH;
`endif

    // ALU code for OP / OP-IMM. For OP-IMM funct3 000 is always ADD
    // (instr[30] is an immediate bit there), while 101 still uses instr[30].
    function automatic logic [3:0] arith_op(input logic [2:0] f3,
                                            input logic       alt,
                                            input logic       is_reg);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (is_reg && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    // ALU comparison used by each branch flavour
    function automatic logic [3:0] branch_op(input logic [2:0] f3);
        logic [3:0] op;
        case (f3)
            3'b000, 3'b001: op = ALU_SUB;
            3'b100, 3'b101: op = ALU_SLT;
            3'b110, 3'b111: op = ALU_SLTU;
            default:        op = ALU_ADD;
        endcase
        return op;
    endfunction

    // Branch decision from the comparison result of the current cycle
    function automatic logic branch_taken(input logic [2:0]  f3,
                                          input logic [31:0] res);
        logic taken;
        case (f3)
            3'b000:  taken = (res == 32'd0);
            3'b001:  taken = (res != 32'd0);
            3'b100:  taken = res[0];
            3'b101:  taken = ~res[0];
            3'b110:  taken = res[0];
            3'b111:  taken = ~res[0];
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

    // Legal opcode check; branch funct3 010/011 are unassigned
    function automatic logic instr_legal(input logic [6:0] opc,
                                         input logic [2:0] f3);
        logic ok;
        case (opc)
            OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE,
            OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: ok = 1'b1;
            OPC_BRANCH: ok = (f3 != 3'b010) && (f3 != 3'b011);
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

    state_t      state_r;
    state_t      state_next_s;
    logic [3:0]  idle_cnt_r;
    logic        idle_done_s;
    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic        alt_s;
    logic        legal_s;
    logic        is_store_s;
    logic        is_load_s;
    logic        unused_instr_bits_s;

    assign opcode_s   = instr[6:0];
    assign funct3_s   = instr[14:12];
    assign alt_s      = instr[30];
    assign legal_s    = instr_legal(opcode_s, funct3_s);
    assign is_store_s = (opcode_s == OPC_STORE);
    assign is_load_s  = (opcode_s == OPC_LOAD);
    assign idle_done_s = (idle_cnt_r == WAIT_LAST);

    // Register and immediate fields are consumed by the datapath only
    assign unused_instr_bits_s = ^{instr[31], instr[29:15], instr[11:7]};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Post-reset idle cycle counter; S_IDLE is only re-entered through reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_r <= 4'd0;
        end else if ((state_r == S_IDLE) && !idle_done_s) begin
            idle_cnt_r <= idle_cnt_r + 4'd1;
        end else begin
            idle_cnt_r <= idle_cnt_r;
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal_r;

    // Sticky illegal-instruction flag, set when S_EXEC sees an illegal opcode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_r <= 1'b0;
        end else if ((state_r == S_EXEC) && !legal_s) begin
            illegal_r <= 1'b1;
        end else begin
            illegal_r <= illegal_r;
        end
    end

    assign illegal_instr = illegal_r;
`else
    assign illegal_instr = 1'b0;
`endif

    // Next-state and datapath control decode
    always_comb begin
        state_next_s  = state_r;
        alu_operation = ALU_ADD;
        alu_src_a     = SRC_A_PC;
        alu_src_b     = SRC_B_RS2;
        result_src    = RES_ALU_OUT;
        pc_src        = 1'b0;
        pc_lsb_clr    = 1'b0;
        addr_src      = 1'b0;
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;

        case (state_r)
            S_IDLE: begin
                if (idle_done_s) begin
                    state_next_s = S_FETCH;
                end else begin
                    state_next_s = S_IDLE;
                end
            end

            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_a = SRC_A_PC;
                alu_src_b = SRC_B_FOUR;
                // Request held with a stable address until the memory accepts
                if (mem_ready) begin
                    ir_write     = 1'b1;
                    pc_write     = 1'b1;
                    state_next_s = S_DECODE;
                end else begin
                    state_next_s = S_FETCH;
                end
            end

            S_DECODE: begin
                // Branch/JAL target, captured by the datapath into alu_out
                alu_src_a    = SRC_A_OLD_PC;
                alu_src_b    = SRC_B_IMM;
                state_next_s = S_EXEC;
            end

            S_EXEC: begin
                case (opcode_s)
                    OPC_OP: begin
                        alu_operation = arith_op(funct3_s, alt_s, 1'b1);
                        alu_src_a     = SRC_A_RS1;
                        alu_src_b     = SRC_B_RS2;
                        state_next_s  = S_WB;
                    end
                    OPC_OP_IMM: begin
                        alu_operation = arith_op(funct3_s, alt_s, 1'b0);
                        alu_src_a     = SRC_A_RS1;
                        alu_src_b     = SRC_B_IMM;
                        state_next_s  = S_WB;
                    end
                    OPC_LOAD, OPC_STORE: begin
                        alu_src_a    = SRC_A_RS1;
                        alu_src_b    = SRC_B_IMM;
                        state_next_s = S_MEM;
                    end
                    OPC_BRANCH: begin
                        if (legal_s) begin
                            alu_operation = branch_op(funct3_s);
                            alu_src_a     = SRC_A_RS1;
                            alu_src_b     = SRC_B_RS2;
                            // Taken target was latched in alu_out during decode
                            if (branch_taken(funct3_s, alu_result)) begin
                                pc_write = 1'b1;
                                pc_src   = 1'b1;
                            end else begin
                                pc_write = 1'b0;
                                pc_src   = 1'b0;
                            end
                            state_next_s = S_FETCH;
                        end else begin
                            state_next_s = ILLEGAL_NEXT;
                        end
                    end
                    OPC_JAL: begin
                        reg_write    = 1'b1;
                        result_src   = RES_PC;
                        pc_write     = 1'b1;
                        pc_src       = 1'b1;
                        state_next_s = S_FETCH;
                    end
                    OPC_JALR: begin
                        // Link value is the PC before this edge (old PC + 4)
                        alu_src_a    = SRC_A_RS1;
                        alu_src_b    = SRC_B_IMM;
                        reg_write    = 1'b1;
                        result_src   = RES_PC;
                        pc_write     = 1'b1;
                        pc_src       = 1'b0;
                        pc_lsb_clr   = 1'b1;
                        state_next_s = S_FETCH;
                    end
                    OPC_LUI: begin
                        alu_src_a    = SRC_A_ZERO;
                        alu_src_b    = SRC_B_IMM;
                        state_next_s = S_WB;
                    end
                    OPC_AUIPC: begin
                        alu_src_a    = SRC_A_OLD_PC;
                        alu_src_b    = SRC_B_IMM;
                        state_next_s = S_WB;
                    end
                    default: begin
                        state_next_s = ILLEGAL_NEXT;
                    end
                endcase
            end

            S_MEM: begin
                mem_req  = 1'b1;
                addr_src = 1'b1;
                mem_we   = is_store_s;
                if (mem_ready) begin
                    state_next_s = is_store_s ? S_FETCH : S_WB;
                end else begin
                    state_next_s = S_MEM;
                end
            end

            S_WB: begin
                reg_write    = 1'b1;
                result_src   = is_load_s ? RES_MEM_DATA : RES_ALU_OUT;
                state_next_s = S_FETCH;
            end

`ifdef CTRL_ILLEGAL_TRAP_EN
            S_TRAP: begin
                state_next_s = S_TRAP;
            end
`endif

            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rv_multicycle_ctrl
//
// Self-checking bench for rv_multicycle_ctrl. A table of instructions is run
// through fetch/decode/execute(/memory)(/writeback) with mem_ready high; the
// expected output word for every cycle is queued when the cycle's stimulus
// is driven and popped when the outputs are sampled. Hand-written sequences
// cover memory wait states, illegal opcodes and reset mid-instruction.
// Inputs change at the falling edge; outputs are sampled 1 time unit later.
// ---------------------------------------------------------------------------
module tb_rv_multicycle_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic [31:0] alu_result;
    logic        mem_ready;
    logic [3:0]  alu_operation;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  result_src;
    logic        pc_src;
    logic        pc_lsb_clr;
    logic        addr_src;
    logic        pc_write;
    logic        ir_write;
    logic        reg_write;
    logic        mem_req;
    logic        mem_we;
    logic        illegal_instr;

    rv_multicycle_ctrl #(.RESET_WAIT(1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr         (instr),
        .alu_result    (alu_result),
        .mem_ready     (mem_ready),
        .alu_operation (alu_operation),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .result_src    (result_src),
        .pc_src        (pc_src),
        .pc_lsb_clr    (pc_lsb_clr),
        .addr_src      (addr_src),
        .pc_write      (pc_write),
        .ir_write      (ir_write),
        .reg_write     (reg_write),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .illegal_instr (illegal_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output word: {op, src_a, src_b, result_src, pc_src, pc_lsb_clr,
    //               addr_src, pc_write, ir_write, reg_write, mem_req,
    //               mem_we, illegal_instr}
    logic [18:0] act;
    assign act = {alu_operation, alu_src_a, alu_src_b, result_src, pc_src,
                  pc_lsb_clr, addr_src, pc_write, ir_write, reg_write,
                  mem_req, mem_we, illegal_instr};

    localparam logic [8:0] F_PCS = 9'b1_0000_0000;
    localparam logic [8:0] F_LSB = 9'b0_1000_0000;
    localparam logic [8:0] F_AS  = 9'b0_0100_0000;
    localparam logic [8:0] F_PW  = 9'b0_0010_0000;
    localparam logic [8:0] F_IW  = 9'b0_0001_0000;
    localparam logic [8:0] F_RW  = 9'b0_0000_1000;
    localparam logic [8:0] F_MR  = 9'b0_0000_0100;
    localparam logic [8:0] F_MW  = 9'b0_0000_0010;
    localparam logic [8:0] F_ILL = 9'b0_0000_0001;

    function automatic logic [18:0] mk(input logic [3:0] op, input logic [1:0] sa,
                                       input logic [1:0] sb, input logic [1:0] rs,
                                       input logic [8:0] fl);
        return {op, sa, sb, rs, fl};
    endfunction

    // Path after S_EXEC
    localparam int P_FETCH = 0;
    localparam int P_WB    = 1;
    localparam int P_LOAD  = 2;
    localparam int P_STORE = 3;

    typedef struct {
        string       name;
        logic [31:0] ins;
        logic [31:0] alu;
        logic [18:0] exp_exec;
        int          path;
    } vec_t;

    typedef struct {
        string       name;
        logic [18:0] exp;
    } sb_t;

    vec_t tbl[$];
    sb_t  sb_q[$];
    int   errors = 0;
    int   checks = 0;

    logic [18:0] e_zero, e_fetch_wait, e_fetch_go, e_dec, e_ls_exec;
    logic [18:0] e_mem_ld, e_mem_st, e_wb_alu, e_wb_ld, e_trap;

    // Queue the expectation, then sample the DUT and compare against it
    task automatic check_now(input logic [18:0] exp, input string name);
        sb_t e;
        sb_q.push_back('{name: name, exp: exp});
        #1;
        e = sb_q.pop_front();
        checks++;
        if (act !== e.exp) begin
            errors++;
            $display("FAIL %s: got %b want %b", e.name, act, e.exp);
        end
    endtask

    task automatic step(input logic [31:0] i, input logic [31:0] a, input logic r,
                        input logic [18:0] exp, input string name);
        @(negedge clk);
        instr      = i;
        alu_result = a;
        mem_ready  = r;
        check_now(exp, name);
    endtask

    task automatic run_instr(input vec_t v);
        step(v.ins, 32'd0, 1'b1, e_fetch_go, {v.name, "_fetch"});
        step(v.ins, 32'd0, 1'b1, e_dec,      {v.name, "_decode"});
        step(v.ins, v.alu, 1'b1, v.exp_exec, {v.name, "_exec"});
        case (v.path)
            P_WB:    step(v.ins, 32'd0, 1'b1, e_wb_alu, {v.name, "_wb"});
            P_LOAD: begin
                step(v.ins, 32'd0, 1'b1, e_mem_ld, {v.name, "_mem"});
                step(v.ins, 32'd0, 1'b1, e_wb_ld,  {v.name, "_wb"});
            end
            P_STORE: step(v.ins, 32'd0, 1'b1, e_mem_st, {v.name, "_mem"});
            default: ;
        endcase
    endtask

    // Reset pulse; outputs must be 0 at once, and fetch resumes after one idle cycle
    task automatic do_reset(input string name);
        @(negedge clk);
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        check_now(e_zero, {name, "_assert"});
        @(negedge clk);
        check_now(e_zero, {name, "_hold"});
        @(negedge clk);
        rst_n = 1'b1;
        check_now(e_zero, {name, "_idle"});
    endtask

    task automatic illegal_case(input logic [31:0] ins, input string name);
        vec_t v;
        v = '{name: name, ins: ins, alu: 32'd0, exp_exec: e_zero, path: P_FETCH};
        run_instr(v);
`ifdef CTRL_ILLEGAL_TRAP_EN
        for (int k = 0; k < 3; k++) begin
            step(32'h0020_81B3, 32'd0, 1'b1, e_trap, {name, "_trap"});
        end
        do_reset({name, "_rst"});
`endif
    endtask

    function automatic void add_vec(input string n, input logic [31:0] i,
                                    input logic [31:0] a, input logic [18:0] e,
                                    input int p);
        tbl.push_back('{name: n, ins: i, alu: a, exp_exec: e, path: p});
    endfunction

    initial begin
        rst_n      = 1'b0;
        instr      = 32'd0;
        alu_result = 32'd0;
        mem_ready  = 1'b0;

        e_zero       = 19'd0;
        e_fetch_wait = mk(4'b0000, 2'b00, 2'b10, 2'b00, F_MR);
        e_fetch_go   = mk(4'b0000, 2'b00, 2'b10, 2'b00, F_MR | F_IW | F_PW);
        e_dec        = mk(4'b0000, 2'b01, 2'b01, 2'b00, 9'd0);
        e_ls_exec    = mk(4'b0000, 2'b10, 2'b01, 2'b00, 9'd0);
        e_mem_ld     = mk(4'b0000, 2'b00, 2'b00, 2'b00, F_MR | F_AS);
        e_mem_st     = mk(4'b0000, 2'b00, 2'b00, 2'b00, F_MR | F_AS | F_MW);
        e_wb_alu     = mk(4'b0000, 2'b00, 2'b00, 2'b00, F_RW);
        e_wb_ld      = mk(4'b0000, 2'b00, 2'b00, 2'b01, F_RW);
        e_trap       = mk(4'b0000, 2'b00, 2'b00, 2'b00, F_ILL);

        // R-type
        add_vec("add",   32'h0020_81B3, 32'd0, mk(4'b0000, 2'b10, 2'b00, 2'b00, 9'd0), P_WB);
        add_vec("sub",   32'h4020_81B3, 32'd0, mk(4'b0001, 2'b10, 2'b00, 2'b00, 9'd0), P_WB);
        add_vec("sll",   32'h0020_91B3, 32'd0, mk(4'b1000, 2'b10, 2'b00, 2'b00, 9'd0), P_WB);
        add_vec("slt",   32'h0020_A1B3, 32'd0, mk(4'b0101, 2'b10, 2'b00, 2'b00, 9'd0), P_WB);
        add_vec("sltu",  32'h0020_B1B3, 32'd0, mk(4'b1001, 2'b10, 2'b00, 2'b00, 9'd0), P_WB);
        add_vec("xor",   32'h0020_C1B3, 32'd0, mk(4'b0100, 2'b10, 2'b00, 2'b00, 9'd0), P_WB);
        add_vec("srl",   32'h0020_D1B3, 32'd0, mk(4'b0110, 2'b10, 2'b00, 2'b00, 9'd0), P_WB);
        add_vec("sra",   32'h4020_D1B3, 32'd0, mk(4'b0111, 2'b10, 2'b00, 2'b00, 9'd0), P_WB);
        add_vec("or",    32'h0020_E1B3, 32'd0, mk(4'b0011, 2'b10, 2'b00, 2'b00, 9'd0), P_WB);
        add_vec("and",   32'h0020_F1B3, 32'd0, mk(4'b0010, 2'b10, 2'b00, 2'b00, 9'd0), P_WB);
        // I-type ALU: addi with imm bit 30 set must stay ADD
        add_vec("addi",  32'hFFF0_8193, 32'd0, mk(4'b0000, 2'b10, 2'b01, 2'b00, 9'd0), P_WB);
        add_vec("slti",  32'h0020_A193, 32'd0, mk(4'b0101, 2'b10, 2'b01, 2'b00, 9'd0), P_WB);
        add_vec("ori",   32'h0020_E193, 32'd0, mk(4'b0011, 2'b10, 2'b01, 2'b00, 9'd0), P_WB);
        add_vec("srai",  32'h4020_D193, 32'd0, mk(4'b0111, 2'b10, 2'b01, 2'b00, 9'd0), P_WB);
        add_vec("srli",  32'h0020_D193, 32'd0, mk(4'b0110, 2'b10, 2'b01, 2'b00, 9'd0), P_WB);
        // Upper immediates
        add_vec("lui",   32'h1234_51B7, 32'd0, mk(4'b0000, 2'b11, 2'b01, 2'b00, 9'd0), P_WB);
        add_vec("auipc", 32'h1234_5197, 32'd0, mk(4'b0000, 2'b01, 2'b01, 2'b00, 9'd0), P_WB);
        // Memory
        add_vec("lw",    32'h0000_A183, 32'd0, e_ls_exec, P_LOAD);
        add_vec("sw",    32'h0020_A023, 32'd0, e_ls_exec, P_STORE);
        // Branches
        add_vec("beq_t",  32'h0020_8463, 32'd0, mk(4'b0001, 2'b10, 2'b00, 2'b00, F_PW | F_PCS), P_FETCH);
        add_vec("beq_nt", 32'h0020_8463, 32'd5, mk(4'b0001, 2'b10, 2'b00, 2'b00, 9'd0), P_FETCH);
        add_vec("bne_t",  32'h0020_9463, 32'd5, mk(4'b0001, 2'b10, 2'b00, 2'b00, F_PW | F_PCS), P_FETCH);
        add_vec("blt_t",  32'h0020_C463, 32'd1, mk(4'b0101, 2'b10, 2'b00, 2'b00, F_PW | F_PCS), P_FETCH);
        add_vec("bge_nt", 32'h0020_D463, 32'd1, mk(4'b0101, 2'b10, 2'b00, 2'b00, 9'd0), P_FETCH);
        add_vec("bltu_t", 32'h0020_E463, 32'd1, mk(4'b1001, 2'b10, 2'b00, 2'b00, F_PW | F_PCS), P_FETCH);
        add_vec("bgeu_nt",32'h0020_F463, 32'd1, mk(4'b1001, 2'b10, 2'b00, 2'b00, 9'd0), P_FETCH);
        // Jumps
        add_vec("jal",   32'h0080_00EF, 32'd0, mk(4'b0000, 2'b00, 2'b00, 2'b11, F_RW | F_PW | F_PCS), P_FETCH);
        add_vec("jalr",  32'h0001_00E7, 32'd0, mk(4'b0000, 2'b10, 2'b01, 2'b11, F_RW | F_PW | F_LSB), P_FETCH);

        // Reset state and the single post-reset idle cycle
        @(negedge clk);
        check_now(e_zero, "reset_state");
        @(negedge clk);
        rst_n = 1'b1;
        check_now(e_zero, "idle_after_reset");

        // First fetch stalled one cycle by memory
        step(32'h0020_81B3, 32'd0, 1'b0, e_fetch_wait, "fetch_wait");

        for (int n = 0; n < tbl.size(); n++) begin
            run_instr(tbl[n]);
        end

        // Load with two wait states in S_MEM
        step(32'h0000_A183, 32'd0, 1'b1, e_fetch_go, "lw_wait_fetch");
        step(32'h0000_A183, 32'd0, 1'b1, e_dec,      "lw_wait_decode");
        step(32'h0000_A183, 32'd0, 1'b1, e_ls_exec,  "lw_wait_exec");
        step(32'h0000_A183, 32'd0, 1'b0, e_mem_ld,   "lw_wait_mem0");
        step(32'h0000_A183, 32'd0, 1'b0, e_mem_ld,   "lw_wait_mem1");
        step(32'h0000_A183, 32'd0, 1'b1, e_mem_ld,   "lw_wait_mem2");
        step(32'h0000_A183, 32'd0, 1'b1, e_wb_ld,    "lw_wait_wb");

        // Illegal opcode and unassigned branch funct3
        illegal_case(32'h0000_0000, "illegal_opc0");
        illegal_case(32'h0020_A463, "illegal_br010");

        // Reset in the middle of a store's memory phase
        step(32'h0020_A023, 32'd0, 1'b1, e_fetch_go, "sw_rst_fetch");
        step(32'h0020_A023, 32'd0, 1'b1, e_dec,      "sw_rst_decode");
        step(32'h0020_A023, 32'd0, 1'b1, e_ls_exec,  "sw_rst_exec");
        step(32'h0020_A023, 32'd0, 1'b0, e_mem_st,   "sw_rst_mem");
        do_reset("mid_mem_rst");
        step(32'h0020_81B3, 32'd0, 1'b1, e_fetch_go, "restart_fetch");
        step(32'h0020_81B3, 32'd0, 1'b1, e_dec,      "restart_decode");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
